masked_sbox_sched: RTL and testbench

//  Sequences the 3-stage, low-randomness, 2nd-order masked LED S-box layer (16 CF_F-based S-boxes).

---
 rtl/masked_sbox_sched_pkg.sv | 35 +++
 rtl/masked_sbox_sched_rand_slot.sv | 57 +++++
 rtl/masked_sbox_sched.sv | 183 ++++++++++++++++++
 tb/tb_masked_sbox_sched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/masked_sbox_sched_pkg.sv
// Shared types and helpers for the 2nd-order masked LED S-box layer scheduler.
// Holds the FSM state encoding, mask-lane geometry and the per-S-box randomness slicer.
package led_masked_pkg;

  localparam int STAGES        = 3;
  localparam int CF_RW         = 6;
  localparam int RS_PER_STAGE  = 2;
  localparam int RAND_PER_SBOX = 8;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_WAIT1 = 4'd1,
    S_EN1   = 4'd2,
    S_WAIT2 = 4'd3,
    S_EN2   = 4'd4,
    S_WAIT3 = 4'd5,
    S_EN3   = 4'd6,
    S_LIN   = 4'd7,
    S_DONE  = 4'd8
  } state_e;

  typedef struct packed {
    logic [RS_PER_STAGE-1:0] rs;
    logic [CF_RW-1:0]        r;
  } lane_t;

  // Low six bits feed the CF mask, the top two bits feed that stage's rs pair.
  function automatic lane_t slice_lane(input logic [RAND_PER_SBOX-1:0] rand_byte);
    lane_t lane;
    lane.r  = rand_byte[CF_RW-1:0];
    lane.rs = rand_byte[RAND_PER_SBOX-1:CF_RW];
    return lane;
  endfunction

endpackage

// File: rtl/masked_sbox_sched_rand_slot.sv
// One stage's mask holding register: loads a fresh randomness word on handshake,
// clears after the stage has consumed it, and otherwise holds its value.
module masked_rand_slot
  import led_masked_pkg::*;
#(
  parameter int NUM_SBOX = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                load_i,
  input  logic                                clr_i,
  input  logic [NUM_SBOX*RAND_PER_SBOX-1:0]   rand_data_i,
  output logic [NUM_SBOX*CF_RW-1:0]           r_o,
  output logic [NUM_SBOX*RS_PER_STAGE-1:0]    rs_o
);

  lane_t                             lanes_s [NUM_SBOX];
  logic [NUM_SBOX*CF_RW-1:0]         r_d;
  logic [NUM_SBOX*CF_RW-1:0]         r_q;
  logic [NUM_SBOX*RS_PER_STAGE-1:0]  rs_d;
  logic [NUM_SBOX*RS_PER_STAGE-1:0]  rs_q;

  for (genvar i = 0; i < NUM_SBOX; i++) begin : g_lane
    assign lanes_s[i] = slice_lane(rand_data_i[i*RAND_PER_SBOX +: RAND_PER_SBOX]);
  end

  always_comb begin
    r_d  = r_q;
    rs_d = rs_q;
    if (load_i) begin
      for (int i = 0; i < NUM_SBOX; i++) begin
        r_d[i*CF_RW +: CF_RW]               = lanes_s[i].r;
        rs_d[i*RS_PER_STAGE +: RS_PER_STAGE] = lanes_s[i].rs;
      end
    end else if (clr_i) begin
      r_d  = '0;
      rs_d = '0;
    end else begin
      r_d  = r_q;
      rs_d = rs_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_q  <= '0;
      rs_q <= '0;
    end else begin
      r_q  <= r_d;
      rs_q <= rs_d;
    end
  end

  assign r_o  = r_q;
  assign rs_o = rs_q;

endmodule

// File: rtl/masked_sbox_sched.sv
// Scheduler for the 3-stage masked LED S-box layer: fetches one randomness word per
// stage, pulses the stage capture enables and opens the linear-layer window between rounds.
module masked_sbox_sched
  import led_masked_pkg::*;
#(
  parameter int NUM_SBOX      = 16,
  parameter int ROUNDS        = 32,
  parameter int LIN_CYCLES    = 1,
  parameter int CLR_AFTER_USE = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic [NUM_SBOX*RAND_PER_SBOX-1:0] rand_data_i,
  input  logic                              rand_valid_i,
  output logic                              rand_ready_o,
  output logic [NUM_SBOX*CF_RW-1:0]         r1_o,
  output logic [NUM_SBOX*CF_RW-1:0]         r2_o,
  output logic [NUM_SBOX*CF_RW-1:0]         r3_o,
  output logic [NUM_SBOX*CF_RW-1:0]         rs_o,
  output logic [2:0]                        stage_en_o,
  output logic                              lin_en_o,
  output logic [7:0]                        round_idx_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [15:0]                       starve_cnt_o
);

  localparam logic [7:0]  LAST_ROUND = 8'(ROUNDS - 1);
  localparam logic [3:0]  LIN_LAST   = 4'(LIN_CYCLES - 1);
  localparam logic        CLR_EN     = (CLR_AFTER_USE != 0);

  state_e      state_q;
  logic [2:0]  stage_en_q;
  logic        lin_en_q;
  logic        done_q;
  logic        busy_q;
  logic [7:0]  round_q;
  logic [3:0]  lin_cnt_q;
  logic [15:0] starve_q;

  logic                   ready_s;
  logic [STAGES-1:0]      load_s;
  logic [STAGES-1:0]      clr_s;
  logic [STAGES-1:0][NUM_SBOX*CF_RW-1:0]        r_s;
  logic [STAGES-1:0][NUM_SBOX*RS_PER_STAGE-1:0] rs_s;

  // Handshake and post-use clear strobes follow directly from the current state.
  always_comb begin
    ready_s = 1'b0;
    load_s  = '0;
    clr_s   = '0;
    case (state_q)
      S_WAIT1: begin
        ready_s   = 1'b1;
        load_s[0] = rand_valid_i;
      end
      S_WAIT2: begin
        ready_s   = 1'b1;
        load_s[1] = rand_valid_i;
      end
      S_WAIT3: begin
        ready_s   = 1'b1;
        load_s[2] = rand_valid_i;
      end
      S_EN1:   clr_s[0] = CLR_EN;
      S_EN2:   clr_s[1] = CLR_EN;
      S_EN3:   clr_s[2] = CLR_EN;
      default: begin
        ready_s = 1'b0;
        load_s  = '0;
        clr_s   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      stage_en_q <= 3'b000;
      lin_en_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      round_q    <= 8'd0;
      lin_cnt_q  <= 4'd0;
      starve_q   <= 16'd0;
    end else begin
      stage_en_q <= 3'b000;
      lin_en_q   <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q  <= S_WAIT1;
            busy_q   <= 1'b1;
            round_q  <= 8'd0;
            starve_q <= 16'd0;
          end
        end
        S_WAIT1, S_WAIT2, S_WAIT3: begin
          if (rand_valid_i) begin
            case (state_q)
              S_WAIT1: begin
                state_q    <= S_EN1;
                stage_en_q <= 3'b001;
              end
              S_WAIT2: begin
                state_q    <= S_EN2;
                stage_en_q <= 3'b010;
              end
              default: begin
                state_q    <= S_EN3;
                stage_en_q <= 3'b100;
              end
            endcase
          end else if (starve_q != 16'hFFFF) begin
            starve_q <= starve_q + 16'd1;
          end
        end
        S_EN1: state_q <= S_WAIT2;
        S_EN2: state_q <= S_WAIT3;
        S_EN3: begin
          if (round_q < LAST_ROUND) begin
            state_q   <= S_LIN;
            lin_en_q  <= 1'b1;
            lin_cnt_q <= 4'd0;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_LIN: begin
          if (lin_cnt_q == LIN_LAST) begin
            state_q <= S_WAIT1;
            round_q <= round_q + 8'd1;
          end else begin
            lin_cnt_q <= lin_cnt_q + 4'd1;
            lin_en_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    masked_rand_slot #(
      .NUM_SBOX(NUM_SBOX)
    ) u_slot (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (load_s[k]),
      .clr_i       (clr_s[k]),
      .rand_data_i (rand_data_i),
      .r_o         (r_s[k]),
      .rs_o        (rs_s[k])
    );
  end

  // Per S-box the three stage rs pairs sit side by side: stage1 low, stage3 high.
  for (genvar i = 0; i < NUM_SBOX; i++) begin : g_rs
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      assign rs_o[i*CF_RW + k*RS_PER_STAGE +: RS_PER_STAGE] =
        rs_s[k][i*RS_PER_STAGE +: RS_PER_STAGE];
    end
  end

  assign r1_o         = r_s[0];
  assign r2_o         = r_s[1];
  assign r3_o         = r_s[2];
  assign rand_ready_o = ready_s;
  assign stage_en_o   = stage_en_q;
  assign lin_en_o     = lin_en_q;
  assign round_idx_o  = round_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign starve_cnt_o = starve_q;

endmodule

// File: tb/tb_masked_sbox_sched.sv
// Self-checking bench for masked_sbox_sched: a timeline model built from the scheduling
// rules predicts every output per cycle; hand tables cover the fixed-timing corner cases.
module tb_masked_sbox_sched;

  localparam int NS   = 16;
  localparam int RW   = NS*8;
  localparam int MW   = NS*6;
  localparam int RND  = 2;
  localparam int LINC = 1;
  localparam int MAXC = 256;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          rand_valid_i = 1'b0;
  logic [RW-1:0] rand_data_i = '0;
  logic          rand_ready_o;
  logic [MW-1:0] r1_o, r2_o, r3_o, rs_o;
  logic [2:0]    stage_en_o;
  logic          lin_en_o;
  logic [7:0]    round_idx_o;
  logic          busy_o;
  logic          done_o;
  logic [15:0]   starve_cnt_o;

  always #5 clk = ~clk;

  masked_sbox_sched #(
    .NUM_SBOX(NS), .ROUNDS(RND), .LIN_CYCLES(LINC), .CLR_AFTER_USE(1)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .rand_data_i(rand_data_i), .rand_valid_i(rand_valid_i), .rand_ready_o(rand_ready_o),
    .r1_o(r1_o), .r2_o(r2_o), .r3_o(r3_o), .rs_o(rs_o),
    .stage_en_o(stage_en_o), .lin_en_o(lin_en_o), .round_idx_o(round_idx_o),
    .busy_o(busy_o), .done_o(done_o), .starve_cnt_o(starve_cnt_o)
  );

  typedef struct packed {
    logic          ready;
    logic [2:0]    se;
    logic          lin;
    logic          done;
    logic          busy;
    logic [7:0]    rnd;
    logic [15:0]   starve;
    logic [MW-1:0] r1;
    logic [MW-1:0] r2;
    logic [MW-1:0] r3;
    logic [MW-1:0] rs;
  } snap_t;

  typedef struct {
    int         cyc;
    logic [2:0] se;
    logic       lin;
    logic       done;
  } ev_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  snap_t         cur;
  snap_t         ex  [MAXC];
  snap_t         obs [MAXC];
  logic          valid_a [MAXC];
  logic          start_a [MAXC];
  logic [RW-1:0] data_a  [MAXC];
  int            end_c;
  ev_t           t1_tab [8];

  function automatic logic [MW-1:0] r_of(input logic [RW-1:0] w);
    logic [MW-1:0] r;
    for (int i = 0; i < NS; i++) r[6*i +: 6] = w[8*i +: 6];
    return r;
  endfunction

  function automatic logic [MW-1:0] rs_of(input logic [RW-1:0] w1, input logic [RW-1:0] w2,
                                          input logic [RW-1:0] w3);
    logic [MW-1:0] r;
    for (int i = 0; i < NS; i++) begin
      r[6*i     +: 2] = w1[8*i+6 +: 2];
      r[6*i + 2 +: 2] = w2[8*i+6 +: 2];
      r[6*i + 4 +: 2] = w3[8*i+6 +: 2];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_snap(input string tag, input int c, input snap_t a, input snap_t e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s cyc%0d: got rdy=%b se=%b lin=%b done=%b busy=%b rnd=%0d stv=%0d r1=%h r2=%h r3=%h rs=%h | expected rdy=%b se=%b lin=%b done=%b busy=%b rnd=%0d stv=%0d r1=%h r2=%h r3=%h rs=%h",
               tag, c, a.ready, a.se, a.lin, a.done, a.busy, a.rnd, a.starve, a.r1, a.r2, a.r3, a.rs,
               e.ready, e.se, e.lin, e.done, e.busy, e.rnd, e.starve, e.r1, e.r2, e.r3, e.rs);
    end
  endtask

  task automatic step(input logic st, input logic v, input logic [RW-1:0] d, input logic r);
    @(posedge clk);
    #1;
    start_i      = st;
    rand_valid_i = v;
    rand_data_i  = d;
    rst_i        = r;
    @(negedge clk);
    cur.ready  = rand_ready_o;
    cur.se     = stage_en_o;
    cur.lin    = lin_en_o;
    cur.done   = done_o;
    cur.busy   = busy_o;
    cur.rnd    = round_idx_o;
    cur.starve = starve_cnt_o;
    cur.r1     = r1_o;
    cur.r2     = r2_o;
    cur.r3     = r3_o;
    cur.rs     = rs_o;
  endtask

  task automatic put(input int c, input logic rdy, input logic [2:0] se, input logic lin,
                     input logic dn, input logic bsy, input int rnd, input logic [15:0] stv,
                     input logic [RW-1:0] w1, input logic [RW-1:0] w2, input logic [RW-1:0] w3);
    ex[c].ready  = rdy;
    ex[c].se     = se;
    ex[c].lin    = lin;
    ex[c].done   = dn;
    ex[c].busy   = bsy;
    ex[c].rnd    = 8'(rnd);
    ex[c].starve = stv;
    ex[c].r1     = r_of(w1);
    ex[c].r2     = r_of(w2);
    ex[c].r3     = r_of(w3);
    ex[c].rs     = rs_of(w1, w2, w3);
  endtask

  // Walks the run as layers of (wait for word, use it) per stage, then the linear window.
  task automatic build_model();
    logic [RW-1:0] w [3];
    logic [15:0]   stv;
    int            c;
    w[0] = '0; w[1] = '0; w[2] = '0;
    stv  = 16'd0;
    c    = 1;
    for (int rd = 0; rd < RND; rd++) begin
      for (int k = 0; k < 3; k++) begin
        while (!valid_a[c] && c < MAXC - 16) begin
          put(c, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, rd, stv, w[0], w[1], w[2]);
          if (stv != 16'hFFFF) stv = stv + 16'd1;
          c++;
        end
        put(c, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, rd, stv, w[0], w[1], w[2]);
        w[k] = data_a[c];
        c++;
        put(c, 1'b0, 3'(1 << k), 1'b0, 1'b0, 1'b1, rd, stv, w[0], w[1], w[2]);
        w[k] = '0;
        c++;
      end
      if (rd < RND - 1) begin
        for (int j = 0; j < LINC; j++) begin
          put(c, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, rd, stv, w[0], w[1], w[2]);
          c++;
        end
      end
    end
    put(c, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, RND - 1, stv, w[0], w[1], w[2]);
    c++;
    put(c, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, RND - 1, stv, w[0], w[1], w[2]);
    end_c = c;
  endtask

  task automatic prep(input bit rand_valid);
    for (int c = 0; c < MAXC; c++) begin
      start_a[c] = 1'b0;
      valid_a[c] = (!rand_valid || c >= MAXC - 24) ? 1'b1 : ($urandom_range(0, 9) < 7);
      data_a[c]  = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic run_seq(input string tag);
    build_model();
    step(1'b1, 1'b0, '0, 1'b0);
    for (int c = 1; c <= end_c; c++) begin
      step(start_a[c], valid_a[c], data_a[c], 1'b0);
      obs[c] = cur;
      check_snap(tag, c, cur, ex[c]);
      n_tests++;
      if (!$onehot0(cur.se) || (cur.lin && cur.se != 3'b000)) begin
        n_fail++;
        $display("FAIL %s excl cyc%0d: got se=%b lin=%b expected one-hot-or-zero se, exclusive with lin",
                 tag, c, cur.se, cur.lin);
      end
    end
  endtask

  task automatic check_t1_table(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s ev@%0d", tag, t1_tab[i].cyc),
            128'({obs[t1_tab[i].cyc].se, obs[t1_tab[i].cyc].lin, obs[t1_tab[i].cyc].done}),
            128'({t1_tab[i].se, t1_tab[i].lin, t1_tab[i].done}));
    end
    check({tag, " end_cycle"}, 128'(end_c), 128'(15));
    check({tag, " rnd@7"}, 128'(obs[7].rnd), 128'(0));
    check({tag, " rnd@8"}, 128'(obs[8].rnd), 128'(1));
    check({tag, " starve@14"}, 128'(obs[14].starve), 128'(0));
    check({tag, " busy@15"}, 128'(obs[15].busy), 128'(0));
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    t1_tab[0] = '{2,  3'b001, 1'b0, 1'b0};
    t1_tab[1] = '{4,  3'b010, 1'b0, 1'b0};
    t1_tab[2] = '{6,  3'b100, 1'b0, 1'b0};
    t1_tab[3] = '{7,  3'b000, 1'b1, 1'b0};
    t1_tab[4] = '{9,  3'b001, 1'b0, 1'b0};
    t1_tab[5] = '{11, 3'b010, 1'b0, 1'b0};
    t1_tab[6] = '{13, 3'b100, 1'b0, 1'b0};
    t1_tab[7] = '{14, 3'b000, 1'b0, 1'b1};

    repeat (3) step(1'b0, 1'b0, '0, 1'b1);
    check_snap("reset", 0, cur, '0);

    // T1 + T2: full-rate run, sbox0 byte of the WAIT2 word is 0xA5.
    prep(1'b0);
    data_a[3][7:0] = 8'hA5;
    run_seq("t1");
    check_t1_table("t1");
    check("t2 r2[5:0]@EN2", 128'(obs[4].r2[5:0]), 128'(6'h25));
    check("t2 rs[3:2]@EN2", 128'(obs[4].rs[3:2]), 128'(2'b10));
    check("t2 r1,r3@EN2", 128'({obs[4].r1, obs[4].r3}), 128'(0));
    check("t2 rs other@EN2", 128'({obs[4].rs[5:4], obs[4].rs[1:0]}), 128'(0));
    check("t2 clr@5", 128'({obs[5].r2, obs[5].rs}), 128'(0));

    // T3: five starved cycles in WAIT3.
    prep(1'b0);
    for (int c = 5; c <= 9; c++) valid_a[c] = 1'b0;
    run_seq("t3");
    check("t3 se@6", 128'(obs[6].se), 128'(3'b000));
    check("t3 se@11", 128'(obs[11].se), 128'(3'b100));
    check("t3 starve@12", 128'(obs[12].starve), 128'(5));
    check("t3 ready stall", 128'(obs[5].ready & obs[6].ready & obs[7].ready & obs[8].ready &
                                 obs[9].ready & obs[10].ready), 128'(1));
    check("t3 done@19", 128'(obs[19].done), 128'(1));

    // T4: start re-pulsed while busy.
    prep(1'b0);
    start_a[3] = 1'b1;
    start_a[8] = 1'b1;
    run_seq("t4");
    check_t1_table("t4");

    // T5: reset during EN2, then a clean run.
    step(1'b1, 1'b0, '0, 1'b0);
    for (int c = 1; c <= 3; c++) step(1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    step(1'b0, 1'b1, '0, 1'b1);
    check("t5 se@EN2", 128'(cur.se), 128'(3'b010));
    step(1'b0, 1'b0, '0, 1'b0);
    check_snap("t5 post-rst", 5, cur, '0);
    step(1'b0, 1'b1, '0, 1'b0);
    check_snap("t5 idle", 6, cur, '0);
    prep(1'b0);
    run_seq("t5b");
    check_t1_table("t5b");

    // Randomized valid patterns, data and spurious starts.
    for (int it = 0; it < 20; it++) begin
      prep(1'b1);
      for (int c = 1; c <= 10; c++) start_a[c] = ($urandom_range(0, 9) == 0);
      run_seq($sformatf("rnd%0d", it));
    end

    // T6: long starvation saturates the counter.
    step(1'b1, 1'b0, '0, 1'b0);
    for (int c = 1; c <= 65541; c++) begin
      step(1'b0, 1'b0, '0, 1'b0);
      if (c == 65535) check("t6 starve@fffe", 128'(cur.starve), 128'(16'hFFFE));
      if (c == 65536) check("t6 starve@ffff", 128'(cur.starve), 128'(16'hFFFF));
      if (c == 65541) check("t6 starve sat", 128'({cur.ready, cur.starve}), 128'({1'b1, 16'hFFFF}));
    end
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    check_snap("t6 reset", 0, cur, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
